ahb_exsram_ctrl: RTL

AHB-Lite slave that drives the external-SRAM pin interface (32-bit bidirectional data, word address, active-low output and write enables) of the FPGA block-RAM SRAM model sitting directly downstream. Translates AHB reads and writes into correctly sequenced SRAM strobe cycles, inserts the wait states the one-cycle-registered SRAM read path requires, and services sub-word writes by read-modify-write because the SRAM has no byte enables.

---
 rtl/ahb_exsram_ctrl_if.sv | 28 ++
 rtl/ahb_exsram_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ahb_exsram_ctrl_if.sv
`default_nettype none
// ============================================================================
// ahb_exsram_ctrl_if : AHB-Lite slave-side bus bundle for ahb_exsram_ctrl
// Revision: 1.0
// ============================================================================
interface ahb_exsram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahb_exsram_ctrl.sv
`default_nettype none
// ============================================================================
// ahb_exsram_ctrl : AHB-Lite to external SRAM pin controller, wait-stated reads
// and (with EXSRAM_RMW_EN) read-modify-write sub-word writes.  Revision: 1.0
// ============================================================================
module ahb_exsram_ctrl #(
  parameter int AW = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ahb_exsram_ctrl_if.slave   ahb,
  inout  wire [31:0]         sram_data_io,
  output logic [AW-1:0]      sram_Address_io,
  output logic               sram_OEn_io,
  output logic               sram_WEn_io
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD1, S_RD2, S_RDONE, S_WR,
    S_RMW1, S_RMW2, S_RMW_WR, S_ERR1, S_ERR2
  } state_t;

  state_t        state_q, state_d, w_first;
  logic [AW-1:0] addr_q;
  logic [31:0]   hrdata_q;
  logic [31:0]   w_bus;
  logic          w_take, w_bad, w_drive;
  logic          unused_ok;

  assign unused_ok = ^{ahb.HADDR[31:AW+2], ahb.HTRANS[0]};
  assign w_take    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & ahb.HREADYOUT;

  always_comb begin
    w_bad = (ahb.HSIZE > 3'd2)
          | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
          | ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] != 2'b00));
`ifndef EXSRAM_RMW_EN
    if (ahb.HWRITE && (ahb.HSIZE < 3'd2)) w_bad = 1'b1;
`endif
    w_first = S_ERR1;
    if (!w_bad) begin
      if (!ahb.HWRITE)              w_first = S_RD1;
      else if (ahb.HSIZE == 3'd2)   w_first = S_WR;
`ifdef EXSRAM_RMW_EN
      else                          w_first = S_RMW1;
`endif
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_RD1:    state_d = S_RD2;
      S_RD2:    state_d = S_RDONE;
      S_ERR1:   state_d = S_ERR2;
`ifdef EXSRAM_RMW_EN
      S_RMW1:   state_d = S_RMW2;
      S_RMW2:   state_d = S_RMW_WR;
`endif
      default:  if (w_take) state_d = w_first;
    endcase
  end

`ifdef EXSRAM_RMW_EN
  logic [1:0]  lane_q;
  logic        half_q;
  logic [31:0] old_q, w_merged;
  logic [3:0]  w_be;

  always_ff @(posedge clk) begin
    if (w_take) begin
      lane_q <= ahb.HADDR[1:0];
      half_q <= ahb.HSIZE[0];
    end
    if (state_q == S_RMW2) old_q <= sram_data_io;
  end

  always_comb begin
    w_be = half_q ? (lane_q[1] ? 4'b1100 : 4'b0011) : (4'b0001 << lane_q);
    for (int i = 0; i < 4; i++)
      w_merged[8*i +: 8] = w_be[i] ? ahb.HWDATA[8*i +: 8] : old_q[8*i +: 8];
  end
`endif

  // Read strobe is always followed by a non-strobe cycle so the SRAM's
  // registered read drive never overlaps a controller write drive.
  always_comb begin
    sram_OEn_io   = 1'b1;
    sram_WEn_io   = 1'b1;
    w_drive       = 1'b0;
    w_bus         = ahb.HWDATA;
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = 1'b0;
    case (state_q)
      S_RD1:    begin sram_OEn_io = 1'b0; ahb.HREADYOUT = 1'b0; end
      S_RD2:    ahb.HREADYOUT = 1'b0;
      S_WR:     begin sram_OEn_io = 1'b0; sram_WEn_io = 1'b0; w_drive = 1'b1; end
      S_ERR1:   begin ahb.HREADYOUT = 1'b0; ahb.HRESP = 1'b1; end
      S_ERR2:   ahb.HRESP = 1'b1;
`ifdef EXSRAM_RMW_EN
      S_RMW1:   begin sram_OEn_io = 1'b0; ahb.HREADYOUT = 1'b0; end
      S_RMW2:   ahb.HREADYOUT = 1'b0;
      S_RMW_WR: begin
        sram_OEn_io = 1'b0;
        sram_WEn_io = 1'b0;
        w_drive     = 1'b1;
        w_bus       = w_merged;
      end
`endif
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_take) addr_q <= ahb.HADDR[AW+1:2];
      if (state_q == S_RD2) hrdata_q <= sram_data_io;
    end
  end

  assign sram_data_io    = w_drive ? w_bus : 32'bz;
  assign sram_Address_io = addr_q;
  assign ahb.HRDATA      = hrdata_q;

endmodule
`default_nettype wire
